switch_mcu_rf_wb_arbiter: RTL and testbench

- Sits between the two write-back sources (execute unit, load unit) and the register file's single write port.
- Arbitrates the sources with valid/ready handshakes and registers the winning write onto the port.
- Keeps a 32-entry busy scoreboard of destination registers with writes outstanding, so decode can stall reads until the data has landed.

---
 rtl/switch_mcu_rf_wb_arbiter.sv | 121 ++++++++++++
 tb/tb_switch_mcu_rf_wb_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/switch_mcu_rf_wb_arbiter.sv
// Write-back arbiter for the register file's single write port, with a busy scoreboard for decode stalls.
// Define SWITCH_MCU_RF_WB_RR_EN for round-robin arbitration; otherwise EX has fixed priority over LD.
module switch_mcu_rf_wb_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_ex_valid,
    input  logic [ADDR_W-1:0]       in_ex_addr,
    input  logic [DATA_W-1:0]       in_ex_data,
    output logic                    out_ex_ready,
    input  logic                    in_ld_valid,
    input  logic [ADDR_W-1:0]       in_ld_addr,
    input  logic [DATA_W-1:0]       in_ld_data,
    output logic                    out_ld_ready,
    output logic                    out_rf_wen,
    output logic [ADDR_W-1:0]       out_rf_waddr,
    output logic [DATA_W-1:0]       out_rf_wdata,
    input  logic                    in_sb_set_en,
    input  logic [ADDR_W-1:0]       in_sb_set_addr,
    input  logic                    in_sb_flush,
    input  logic [ADDR_W-1:0]       in_rs1_addr,
    input  logic                    in_rs1_ren,
    input  logic [ADDR_W-1:0]       in_rs2_addr,
    input  logic                    in_rs2_ren,
    output logic                    out_stall,
    output logic [(1<<ADDR_W)-1:0]  out_busy
);

    localparam int NREG = 1 << ADDR_W;

    logic              ex_gnt;
    logic              ld_gnt;
    logic              vld_p0;
    logic [ADDR_W-1:0] waddr_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic              vld_p1;
    logic [ADDR_W-1:0] waddr_p1;
    logic [DATA_W-1:0] wdata_p1;
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;

`ifdef SWITCH_MCU_RF_WB_RR_EN
    // ptr_ld_q high means LD wins the next contended cycle
    logic ptr_ld_q;

    always_comb begin
        ex_gnt = in_ex_valid & (~in_ld_valid | ~ptr_ld_q);
        ld_gnt = in_ld_valid & (~in_ex_valid | ptr_ld_q);
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst)
            ptr_ld_q <= 1'b0;
        else if (ex_gnt)
            ptr_ld_q <= 1'b1;
        else if (ld_gnt)
            ptr_ld_q <= 1'b0;
    end
`else
    always_comb begin
        ex_gnt = in_ex_valid;
        ld_gnt = in_ld_valid & ~in_ex_valid;
    end
`endif

    assign out_ex_ready = ex_gnt;
    assign out_ld_ready = ld_gnt;

    // Stage p0: select the winner; writes to r0 are accepted but never reach the port
    always_comb begin
        waddr_p0 = ex_gnt ? in_ex_addr : in_ld_addr;
        wdata_p0 = ex_gnt ? in_ex_data : in_ld_data;
        vld_p0   = (ex_gnt | ld_gnt) & (waddr_p0 != '0);
    end

    // Stage p1: registered write port; addr/data hold when nothing is granted
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            vld_p1   <= 1'b0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (ex_gnt | ld_gnt) begin
                waddr_p1 <= waddr_p0;
                wdata_p1 <= wdata_p0;
            end
        end
    end

    assign out_rf_wen   = vld_p1;
    assign out_rf_waddr = waddr_p1;
    assign out_rf_wdata = wdata_p1;

    // Set is applied after clear so a newer producer keeps the register busy
    always_comb begin
        busy_d = busy_q;
        if (in_sb_flush) begin
            busy_d = '0;
        end else begin
            if (vld_p1)
                busy_d[waddr_p1] = 1'b0;
            if (in_sb_set_en)
                busy_d[in_sb_set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign out_busy  = busy_q;
    assign out_stall = (in_rs1_ren & busy_q[in_rs1_addr]) | (in_rs2_ren & busy_q[in_rs2_addr]);

endmodule

// File: tb/tb_switch_mcu_rf_wb_arbiter.sv
// Directed bench for switch_mcu_rf_wb_arbiter; expectations are hand-computed per step.
module tb_switch_mcu_rf_wb_arbiter;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        in_ex_valid, in_ld_valid;
    logic [4:0]  in_ex_addr, in_ld_addr;
    logic [31:0] in_ex_data, in_ld_data;
    logic        out_ex_ready, out_ld_ready;
    logic        out_rf_wen;
    logic [4:0]  out_rf_waddr;
    logic [31:0] out_rf_wdata;
    logic        in_sb_set_en, in_sb_flush;
    logic [4:0]  in_sb_set_addr;
    logic [4:0]  in_rs1_addr, in_rs2_addr;
    logic        in_rs1_ren, in_rs2_ren;
    logic        out_stall;
    logic [31:0] out_busy;

    int errors = 0;
    int checks = 0;

    always #5 in_clk = ~in_clk;

    switch_mcu_rf_wb_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .in_clk(in_clk), .in_rst(in_rst),
        .in_ex_valid(in_ex_valid), .in_ex_addr(in_ex_addr), .in_ex_data(in_ex_data),
        .out_ex_ready(out_ex_ready),
        .in_ld_valid(in_ld_valid), .in_ld_addr(in_ld_addr), .in_ld_data(in_ld_data),
        .out_ld_ready(out_ld_ready),
        .out_rf_wen(out_rf_wen), .out_rf_waddr(out_rf_waddr), .out_rf_wdata(out_rf_wdata),
        .in_sb_set_en(in_sb_set_en), .in_sb_set_addr(in_sb_set_addr), .in_sb_flush(in_sb_flush),
        .in_rs1_addr(in_rs1_addr), .in_rs1_ren(in_rs1_ren),
        .in_rs2_addr(in_rs2_addr), .in_rs2_ren(in_rs2_ren),
        .out_stall(out_stall), .out_busy(out_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    initial begin
        logic exp_ex;
        in_rst = 1'b0;
        in_ex_valid = 0; in_ex_addr = 0; in_ex_data = 0;
        in_ld_valid = 0; in_ld_addr = 0; in_ld_data = 0;
        in_sb_set_en = 0; in_sb_set_addr = 0; in_sb_flush = 0;
        in_rs1_addr = 0; in_rs1_ren = 0; in_rs2_addr = 0; in_rs2_ren = 0;

        // Reset then idle
        #12;
        check("rst_wen", out_rf_wen, 0);
        check("rst_waddr", out_rf_waddr, 0);
        check("rst_wdata", out_rf_wdata, 0);
        check("rst_busy", out_busy, 0);
        check("rst_ex_ready", out_ex_ready, 0);
        check("rst_ld_ready", out_ld_ready, 0);
        check("rst_stall", out_stall, 0);
        in_rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_wen", out_rf_wen, 0);
        end

        // Contention: EX addr 3, LD addr 4, both valid for 4 cycles
        in_ex_valid = 1; in_ex_addr = 5'd3; in_ex_data = 32'hAAAA_0003;
        in_ld_valid = 1; in_ld_addr = 5'd4; in_ld_data = 32'hBBBB_0004;
        for (int i = 0; i < 4; i++) begin
`ifdef SWITCH_MCU_RF_WB_RR_EN
            exp_ex = (i % 2 == 0);
`else
            exp_ex = 1'b1;
`endif
            #1;
            check("cont_ex_ready", out_ex_ready, exp_ex);
            check("cont_ld_ready", out_ld_ready, !exp_ex);
            tick();
            check("cont_wen", out_rf_wen, 1);
            check("cont_waddr", out_rf_waddr, exp_ex ? 32'd3 : 32'd4);
            check("cont_wdata", out_rf_wdata, exp_ex ? 32'hAAAA_0003 : 32'hBBBB_0004);
        end
        in_ex_valid = 0;
`ifndef SWITCH_MCU_RF_WB_RR_EN
        #1;
        check("starve_ld_ready", out_ld_ready, 1);
        tick();
        check("starve_waddr", out_rf_waddr, 4);
        check("starve_wdata", out_rf_wdata, 32'hBBBB_0004);
`endif
        in_ld_valid = 0;
        tick();
        check("cont_idle_wen", out_rf_wen, 0);

        // Single EX write to r5, set busy two cycles ahead
        in_sb_set_en = 1; in_sb_set_addr = 5'd5;
        tick();
        in_sb_set_en = 0;
        in_rs1_ren = 1; in_rs1_addr = 5'd5;
        #1;
        check("ex_busy_pre", out_busy[5], 1);
        check("ex_stall_pre", out_stall, 1);
        tick();
        in_ex_valid = 1; in_ex_addr = 5'd5; in_ex_data = 32'hDEADBEEF;
        #1;
        check("ex_ready_n", out_ex_ready, 1);
        check("ex_ld_ready_n", out_ld_ready, 0);
        check("ex_stall_n", out_stall, 1);
        tick();
        in_ex_valid = 0;
        check("ex_wen_n1", out_rf_wen, 1);
        check("ex_waddr_n1", out_rf_waddr, 5);
        check("ex_wdata_n1", out_rf_wdata, 32'hDEADBEEF);
        check("ex_busy_n1", out_busy[5], 1);
        check("ex_stall_n1", out_stall, 1);
        tick();
        check("ex_wen_n2", out_rf_wen, 0);
        check("ex_waddr_hold", out_rf_waddr, 5);
        check("ex_wdata_hold", out_rf_wdata, 32'hDEADBEEF);
        check("ex_busy_n2", out_busy[5], 0);
        check("ex_stall_n2", out_stall, 0);
        in_rs1_ren = 0;

        // Register 0 write and set
        in_ld_valid = 1; in_ld_addr = 5'd0; in_ld_data = 32'h1234;
        in_sb_set_en = 1; in_sb_set_addr = 5'd0;
        #1;
        check("r0_ld_ready", out_ld_ready, 1);
        tick();
        in_ld_valid = 0; in_sb_set_en = 0;
        check("r0_wen", out_rf_wen, 0);
        check("r0_busy", out_busy, 0);

        // Set/clear collision on r7, then flush with a set of r9
        in_sb_set_en = 1; in_sb_set_addr = 5'd7;
        tick();
        in_sb_set_en = 0;
        in_ex_valid = 1; in_ex_addr = 5'd7; in_ex_data = 32'h0000_0077;
        tick();
        in_ex_valid = 0;
        in_sb_set_en = 1; in_sb_set_addr = 5'd7;
        check("col_wen", out_rf_wen, 1);
        check("col_waddr", out_rf_waddr, 7);
        tick();
        in_sb_set_en = 0;
        check("col_busy7", out_busy, 32'h0000_0080);
        in_sb_flush = 1; in_sb_set_en = 1; in_sb_set_addr = 5'd9;
        tick();
        in_sb_flush = 0; in_sb_set_en = 0;
        check("flush_busy", out_busy, 0);

        // Async reset while a write is on the port
        in_sb_set_en = 1; in_sb_set_addr = 5'd6;
        tick();
        in_sb_set_en = 0;
        in_ex_valid = 1; in_ex_addr = 5'd6; in_ex_data = 32'hCAFE_0006;
        tick();
        in_ex_valid = 0;
        check("arst_pre_wen", out_rf_wen, 1);
        check("arst_pre_busy", out_busy, 32'h0000_0040);
        #2;
        in_rst = 1'b0;
        #1;
        check("arst_wen", out_rf_wen, 0);
        check("arst_busy", out_busy, 0);
        check("arst_waddr", out_rf_waddr, 0);
        check("arst_wdata", out_rf_wdata, 0);
        #10;
        in_rst = 1'b1;
        tick();
        check("post_rst_wen", out_rf_wen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
